// File: rtl/regfile_wb_ctrl_if.sv
// Handshake, write-port and bypass bundle between the write-back controller
// and its producers/consumers. The controller uses the slave modport.
interface regfile_wb_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 24
);
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [AW-1:0] byp_addr1;
  logic [AW-1:0] byp_addr2;
  logic          byp_hit1;
  logic          byp_hit2;
  logic [DW-1:0] byp_data1;
  logic [DW-1:0] byp_data2;
  logic          busy;

  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
           byp_addr1, byp_addr2,
    input  alu_ready, ld_ready, write_enable, write_addr, write_data,
           byp_hit1, byp_hit2, byp_data1, byp_data2, busy
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
           byp_addr1, byp_addr2,
    output alu_ready, ld_ready, write_enable, write_addr, write_data,
           byp_hit1, byp_hit2, byp_data1, byp_data2, busy
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: merges ALU and load results onto one
// write port, queues loads, keeps per-register write order, exposes bypass.

// Per-entry address compare; register 0 never matches anything.
module regfile_wb_lq_cmp #(
  parameter int AW = 4
) (
  input  logic          vld_i,
  input  logic [AW-1:0] ent_addr_i,
  input  logic [AW-1:0] alu_addr_i,
  input  logic [AW-1:0] byp1_addr_i,
  input  logic [AW-1:0] byp2_addr_i,
  output logic          alu_hit_o,
  output logic          byp1_hit_o,
  output logic          byp2_hit_o
);
  logic live;
  assign live       = vld_i && (ent_addr_i != '0);
  assign alu_hit_o  = live && (ent_addr_i == alu_addr_i);
  assign byp1_hit_o = live && (ent_addr_i == byp1_addr_i);
  assign byp2_hit_o = live && (ent_addr_i == byp2_addr_i);
endmodule

module regfile_wb_ctrl #(
  parameter int REGFILE_ADDR_BITS = 4,
  parameter int DATA_BUS_WIDTH    = 24,
  parameter int LQ_DEPTH          = 4,
  parameter int STARVE_LIMIT      = 8
) (
  input logic              clk,
  input logic              rst_n,
  regfile_wb_ctrl_if.slave bus
);
  localparam int AW = REGFILE_ADDR_BITS;
  localparam int DW = DATA_BUS_WIDTH;
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [PW:0]   LQ_FULL    = (PW+1)'(LQ_DEPTH);

  typedef enum logic {ST_NORMAL, ST_DRAIN} state_e;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  state_e                     state_q, state_d;
  logic [SW-1:0]              starve_q, starve_d;
  logic [PW:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]                occ, occ_d;
  logic [PW-1:0]              wr_idx, rd_idx, age_idx;
  wb_req_t [LQ_DEPTH-1:0]     lq_q;
  wb_req_t                    wr_q, iss_d;
  logic                       we_q, we_d;
  logic                       empty, full, push, pop, alu_rdy, alu_fire;
  logic [LQ_DEPTH-1:0]        ent_vld, alu_hit, b1_hit, b2_hit;
  logic                       byp1_hit, byp2_hit;
  logic [DW-1:0]              byp1_data, byp2_data;

  // Queue pointers carry one wrap bit above the index.
  assign wr_idx = wr_ptr_q[PW-1:0];
  assign rd_idx = rd_ptr_q[PW-1:0];
  assign occ    = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PW] != rd_ptr_q[PW]);

  for (genvar g = 0; g < LQ_DEPTH; g++) begin : g_ent
    assign ent_vld[g] = ({1'b0, PW'(g) - rd_idx} < occ);
    regfile_wb_lq_cmp #(.AW(AW)) u_cmp (
      .vld_i      (ent_vld[g]),
      .ent_addr_i (lq_q[g].addr),
      .alu_addr_i (bus.alu_addr),
      .byp1_addr_i(bus.byp_addr1),
      .byp2_addr_i(bus.byp_addr2),
      .alu_hit_o  (alu_hit[g]),
      .byp1_hit_o (b1_hit[g]),
      .byp2_hit_o (b2_hit[g])
    );
  end

  // An ALU write must not overtake a queued load to the same register.
  assign alu_rdy  = (state_q == ST_NORMAL) && !(|alu_hit);
  assign alu_fire = bus.alu_valid && alu_rdy;
  assign push     = bus.ld_valid && !full;
  assign pop      = !empty && ((state_q == ST_DRAIN) || !alu_fire);
  assign wr_ptr_d = wr_ptr_q + (PW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
  assign occ_d    = wr_ptr_d - rd_ptr_d;

  always_comb begin
    we_d  = 1'b0;
    iss_d = wr_q;
    if (alu_fire) begin
      we_d  = (bus.alu_addr != '0);
      iss_d = '{addr: bus.alu_addr, data: bus.alu_data};
    end else if (pop) begin
      we_d  = (lq_q[rd_idx].addr != '0);
      iss_d = lq_q[rd_idx];
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      ST_NORMAL: begin
        if (pop) starve_d = '0;
        else if (!empty && (starve_q != STARVE_MAX)) starve_d = starve_q + SW'(1);
        if ((occ_d == LQ_FULL) || (starve_d == STARVE_MAX)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        starve_d = '0;
        if (occ_d == '0) state_d = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      we_q     <= 1'b0;
      wr_q     <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      we_q     <= we_d;
      wr_q     <= iss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) lq_q[wr_idx] <= '{addr: bus.ld_addr, data: bus.ld_data};
  end

  // Walk the queue oldest to newest so the newest match wins; the queue is
  // younger than the output register, so it overrides it.
  always_comb begin
    byp1_hit  = 1'b0;
    byp1_data = '0;
    byp2_hit  = 1'b0;
    byp2_data = '0;
    age_idx   = '0;
    if (we_q && (bus.byp_addr1 != '0) && (wr_q.addr == bus.byp_addr1)) begin
      byp1_hit  = 1'b1;
      byp1_data = wr_q.data;
    end
    if (we_q && (bus.byp_addr2 != '0) && (wr_q.addr == bus.byp_addr2)) begin
      byp2_hit  = 1'b1;
      byp2_data = wr_q.data;
    end
    for (int k = 0; k < LQ_DEPTH; k++) begin
      age_idx = rd_idx + PW'(k);
      if (b1_hit[age_idx]) begin
        byp1_hit  = 1'b1;
        byp1_data = lq_q[age_idx].data;
      end
      if (b2_hit[age_idx]) begin
        byp2_hit  = 1'b1;
        byp2_data = lq_q[age_idx].data;
      end
    end
  end

  assign bus.alu_ready    = alu_rdy;
  assign bus.ld_ready     = !full;
  assign bus.write_enable = we_q;
  assign bus.write_addr   = wr_q.addr;
  assign bus.write_data   = wr_q.data;
  assign bus.byp_hit1     = byp1_hit;
  assign bus.byp_hit2     = byp2_hit;
  assign bus.byp_data1    = byp1_data;
  assign bus.byp_data2    = byp2_data;
  assign bus.busy         = !empty || we_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: ALU vector table, per-register ordering
// scoreboard, and hand sequences for ordering, drain, starvation and reset.
module tb_regfile_wb_ctrl;
  localparam int AW = 4;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  regfile_wb_ctrl #(
    .REGFILE_ADDR_BITS(AW), .DATA_BUS_WIDTH(DW), .LQ_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted transfer to a nonzero register, in acceptance
  // order. Each observed write must match the oldest pending entry for its
  // register, which checks both data and per-register ordering.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t sb[$];
  int  sb_idx;

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.alu_valid && bus.alu_ready && bus.alu_addr != '0)
        sb.push_back('{bus.alu_addr, bus.alu_data});
      if (bus.ld_valid && bus.ld_ready && bus.ld_addr != '0)
        sb.push_back('{bus.ld_addr, bus.ld_data});
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.write_enable) begin
      sb_idx = -1;
      foreach (sb[i]) if (sb_idx < 0 && sb[i].a == bus.write_addr) sb_idx = i;
      if (sb_idx < 0) begin
        n_chk++;
        $display("FAIL sb_extra_write: got write r%0d=0x%0h, want no write",
                 bus.write_addr, bus.write_data);
      end else begin
        chk("sb_order_data", 32'(bus.write_data), 32'(sb[sb_idx].d));
        sb.delete(sb_idx);
      end
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          exp_we;
  } vec_t;
  vec_t vt[6];

  int found;
  int strobes;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4'd3,  24'h00ABCD, 1'b1};
    vt[1] = '{4'd0,  24'h123456, 1'b0};
    vt[2] = '{4'd15, 24'hFFFFFF, 1'b1};
    vt[3] = '{4'd1,  24'h000000, 1'b1};
    vt[4] = '{4'd8,  24'h800001, 1'b1};
    vt[5] = '{4'd0,  24'hFFFFFF, 1'b0};

    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_data  = '0;
    bus.byp_addr1 = 4'd3; bus.byp_addr2 = 4'd5;

    // Reset and idle
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_we",        32'(bus.write_enable), 32'd0);
    chk("rst_busy",      32'(bus.busy),         32'd0);
    chk("rst_alu_ready", 32'(bus.alu_ready),    32'd1);
    chk("rst_ld_ready",  32'(bus.ld_ready),     32'd1);
    chk("rst_byp_hit1",  32'(bus.byp_hit1),     32'd0);
    chk("rst_byp_hit2",  32'(bus.byp_hit2),     32'd0);

    // Single ALU writes, including register 0
    for (int i = 0; i < 6; i++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = vt[i].a; bus.alu_data = vt[i].d;
      bus.byp_addr1 = vt[i].a;
      #1 chk("vec_alu_ready", 32'(bus.alu_ready), 32'd1);
      tick();
      bus.alu_valid = 1'b0;
      chk("vec_we",   32'(bus.write_enable), 32'(vt[i].exp_we));
      chk("vec_busy", 32'(bus.busy),         32'(vt[i].exp_we));
      chk("vec_byp_hit", 32'(bus.byp_hit1),  32'(vt[i].exp_we));
      if (vt[i].exp_we) begin
        chk("vec_addr",     32'(bus.write_addr), 32'(vt[i].a));
        chk("vec_data",     32'(bus.write_data), 32'(vt[i].d));
        chk("vec_byp_data", 32'(bus.byp_data1),  32'(vt[i].d));
      end else begin
        chk("vec_byp_data_r0", 32'(bus.byp_data1), 32'd0);
      end
      tick();
      chk("vec_we_drop", 32'(bus.write_enable), 32'd0);
    end

    // Ordering: load r5 queued behind an ALU stream to r1, then ALU offers r5
    bus.ld_valid = 1'b1; bus.ld_addr = 4'd5; bus.ld_data = 24'h111111;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd1; bus.alu_data = 24'h0A0001;
    tick();
    bus.ld_valid = 1'b0;
    bus.alu_data = 24'h0A0002;
    tick();
    bus.alu_data = 24'h0A0003;
    tick();
    bus.alu_addr = 4'd5; bus.alu_data = 24'h222222;
    bus.byp_addr1 = 4'd5; bus.byp_addr2 = 4'd1;
    #1;
    chk("ord_alu_blocked", 32'(bus.alu_ready), 32'd0);
    chk("ord_byp_hit1",    32'(bus.byp_hit1),  32'd1);
    chk("ord_byp_data1",   32'(bus.byp_data1), 32'h111111);
    chk("ord_byp_hit2",    32'(bus.byp_hit2),  32'd1);
    chk("ord_byp_data2",   32'(bus.byp_data2), 32'h0A0003);
    found = 0;
    for (int k = 1; k <= 10 && found == 0; k++) begin
      tick();
      if (bus.write_enable && bus.write_addr == 4'd5) found = k;
    end
    chk("ord_load_issued", 32'(found != 0), 32'd1);
    chk("ord_load_data",   32'(bus.write_data), 32'h111111);
    chk("ord_alu_ready",   32'(bus.alu_ready),  32'd1);
    tick();
    bus.alu_valid = 1'b0;
    chk("ord_alu_we",   32'(bus.write_enable), 32'd1);
    chk("ord_alu_addr", 32'(bus.write_addr),   32'd5);
    chk("ord_alu_data", 32'(bus.write_data),   32'h222222);
    repeat (2) tick();

    // Fill and drain: four loads back-to-back under continuous ALU traffic
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd2;
    bus.ld_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.ld_addr = AW'(6 + k); bus.ld_data = 24'h600000 + DW'(k);
      bus.alu_data = 24'h200000 + DW'(k);
      #1 chk("fill_ld_ready", 32'(bus.ld_ready), 32'd1);
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.alu_data = 24'h200010;
    chk("fill_full_ld_ready", 32'(bus.ld_ready), 32'd0);
    found = 0;
    for (int w = 0; w < 6 && found == 0; w++) begin
      if (!bus.alu_ready) found = 1;
      else tick();
    end
    chk("drain_alu_blocked", 32'(found), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_we",   32'(bus.write_enable), 32'd1);
      chk("drain_addr", 32'(bus.write_addr),   32'(6 + k));
      chk("drain_data", 32'(bus.write_data),   32'h600000 + 32'(k));
    end
    chk("drain_back_normal", 32'(bus.alu_ready), 32'd1);
    bus.alu_valid = 1'b0;
    repeat (3) tick();

    // Starvation: one load behind continuous ALU traffic
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd2; bus.alu_data = 24'h2A2A2A;
    bus.ld_valid = 1'b1; bus.ld_addr = 4'd7; bus.ld_data = 24'h777777;
    tick();
    bus.ld_valid = 1'b0;
    found = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      if (bus.write_enable && bus.write_addr == 4'd7) found = k;
      else tick();
    end
    chk("starve_issued",     32'(found != 0), 32'd1);
    chk("starve_latency_ok", 32'(found >= 2 && found <= 10), 32'd1);
    bus.alu_valid = 1'b0;
    repeat (3) tick();

    // Reset with three loads queued
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd2; bus.alu_data = 24'h0B0B0B;
    bus.ld_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.ld_addr = AW'(10 + k); bus.ld_data = 24'hA00000 + DW'(k);
      tick();
    end
    bus.ld_valid = 1'b0; bus.alu_valid = 1'b0;
    bus.byp_addr1 = 4'd10; bus.byp_addr2 = 4'd0;
    #1 chk("midrst_busy_before", 32'(bus.busy), 32'd1);
    chk("midrst_byp_before", 32'(bus.byp_hit1), 32'd1);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_we",       32'(bus.write_enable), 32'd0);
    chk("midrst_busy",     32'(bus.busy),         32'd0);
    chk("midrst_ld_ready", 32'(bus.ld_ready),     32'd1);
    chk("midrst_byp_hit1", 32'(bus.byp_hit1),     32'd0);
    chk("midrst_byp_hit2", 32'(bus.byp_hit2),     32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.write_enable) strobes++;
    end
    chk("midrst_no_strobe", 32'(strobes), 32'd0);
    chk("sb_all_retired",   32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
